// File: rtl/cnn_l1_pkg.sv
// Shared widths, FSM state type and saturation limits for the layer-1 convolution MAC.
package cnn_l1_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WGT_W  = 8;
    localparam int unsigned ACC_W  = 27;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned DIM_W  = 9;
    localparam int unsigned ADDR_W = 18;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    // Limits expressed at accumulator width for comparison, and at output width for the clamp value
    localparam logic signed [ACC_W-1:0] SAT_HI_ACC = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO_ACC = ~SAT_HI_ACC;
    localparam logic [OUT_W-1:0]        SAT_HI     = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0]        SAT_LO     = {1'b1, {(OUT_W - 1){1'b0}}};

endpackage

// File: rtl/sat_relu_l1.sv
// Combinational signed saturation of the window sum to OUT_W, with optional ReLU.
// Build option: define CONV_L1_RELU_EN to clamp negative results to zero.
module sat_relu_l1
    import cnn_l1_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc_in,
    output logic        [OUT_W-1:0] res_c
);

    logic [OUT_W-1:0] sat;

    always_comb begin
        sat = acc_in[OUT_W-1:0];
        if (acc_in > SAT_HI_ACC) begin
            sat = SAT_HI;
        end else if (acc_in < SAT_LO_ACC) begin
            sat = SAT_LO;
        end
`ifdef CONV_L1_RELU_EN
        res_c = sat[OUT_W-1] ? '0 : sat;
`else
        res_c = sat;
`endif
    end

endmodule

// File: rtl/conv_mac_l1.sv
// Layer-1 convolution MAC: 3-stage pipeline (flag capture, multiply, accumulate/emit).
// Build option: CONV_L1_RELU_EN (evaluated in sat_relu_l1) enables ReLU on results.
module conv_mac_l1 #(
    parameter int unsigned PIX_W = cnn_l1_pkg::PIX_W,
    parameter int unsigned WGT_W = cnn_l1_pkg::WGT_W,
    parameter int unsigned ACC_W = cnn_l1_pkg::ACC_W,
    parameter int unsigned OUT_W = cnn_l1_pkg::OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [9:0]              count,
    input  logic [8:0]              ht_sm,
    input  logic [8:0]              wt_sm,
    input  logic [8:0]              ht_lg,
    input  logic [8:0]              wt_lg,
    input  logic [PIX_W-1:0]        pix_in,
    input  logic signed [WGT_W-1:0] wgt_in,
    output logic [OUT_W-1:0]        result,
    output logic                    result_valid,
    output logic [17:0]             result_addr,
    output logic                    layer_done
);

    import cnn_l1_pkg::*;

    localparam int unsigned PROD_W = PIX_W + WGT_W + 1;

    // Stage 0: element flags
    logic v0_q, v0_d, last0_q, last0_d, first0_q, first0_d;
    // Stage 1: product
    logic v1_q, v1_d, last1_q, last1_d, first1_q, first1_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    // Stage 2: accumulator, FSM, output index and registered outputs
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, prod_ext;
    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d, result_addr_q, result_addr_d;
    logic [OUT_W-1:0]        result_q, result_d, sat_c;
    logic                    result_valid_q, result_valid_d;
    logic                    layer_done_q, layer_done_d;

    logic [CNT_W-1:0]  kern_last;
    logic [DIM_W-1:0]  out_h, out_w;
    logic [ADDR_W-1:0] idx_last;

    sat_relu_l1 u_sat (
        .acc_in (acc_sum),
        .res_c  (sat_c)
    );

    always_comb begin
        kern_last = CNT_W'(ht_sm * wt_sm - 18'd1);
        out_h     = DIM_W'(ht_lg - ht_sm + 9'd1);
        out_w     = DIM_W'(wt_lg - wt_sm + 9'd1);
        idx_last  = ADDR_W'(out_h * out_w) - ADDR_W'(1);

        v0_d     = en;
        last0_d  = (count == kern_last);
        first0_d = (count == '0);

        v1_d     = v0_q;
        last1_d  = last0_q;
        first1_d = first0_q;
        prod_d   = prod_q;
        if (v0_q) begin
            prod_d = PROD_W'($signed({1'b0, pix_in})) * PROD_W'(wgt_in);
        end

        // A new window restarts the sum even when it follows the previous window with no gap
        prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
        if (first1_q || state_q == IDLE) begin
            acc_sum = prod_ext;
        end else begin
            acc_sum = acc_q + prod_ext;
        end

        acc_d          = acc_q;
        state_d        = state_q;
        idx_d          = idx_q;
        result_d       = result_q;
        result_addr_d  = result_addr_q;
        result_valid_d = 1'b0;
        layer_done_d   = 1'b0;
        if (v1_q) begin
            acc_d = acc_sum;
            if (last1_q) begin
                state_d        = IDLE;
                result_d       = sat_c;
                result_valid_d = 1'b1;
                result_addr_d  = idx_q;
                if (idx_q == idx_last) begin
                    layer_done_d = 1'b1;
                    idx_d        = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end else begin
                state_d = ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q           <= 1'b0;
            last0_q        <= 1'b0;
            first0_q       <= 1'b0;
            v1_q           <= 1'b0;
            last1_q        <= 1'b0;
            first1_q       <= 1'b0;
            prod_q         <= '0;
            acc_q          <= '0;
            state_q        <= IDLE;
            idx_q          <= '0;
            result_q       <= '0;
            result_addr_q  <= '0;
            result_valid_q <= 1'b0;
            layer_done_q   <= 1'b0;
        end else begin
            v0_q           <= v0_d;
            last0_q        <= last0_d;
            first0_q       <= first0_d;
            v1_q           <= v1_d;
            last1_q        <= last1_d;
            first1_q       <= first1_d;
            prod_q         <= prod_d;
            acc_q          <= acc_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            result_q       <= result_d;
            result_addr_q  <= result_addr_d;
            result_valid_q <= result_valid_d;
            layer_done_q   <= layer_done_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_addr  = result_addr_q;
    assign layer_done   = layer_done_q;

endmodule

// File: tb/tb_conv_mac_l1.sv
// Testbench for conv_mac_l1: table of layer configurations checked against a window-sum model.
module tb_conv_mac_l1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic [9:0]        count = '0;
    logic [8:0]        ht_sm = 9'd1, wt_sm = 9'd1, ht_lg = 9'd1, wt_lg = 9'd1;
    logic [7:0]        pix_in = '0;
    logic signed [7:0] wgt_in = '0;
    logic [15:0]       result;
    logic              result_valid;
    logic [17:0]       result_addr;
    logic              layer_done;

    conv_mac_l1 dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .count        (count),
        .ht_sm        (ht_sm),
        .wt_sm        (wt_sm),
        .ht_lg        (ht_lg),
        .wt_lg        (wt_lg),
        .pix_in       (pix_in),
        .wgt_in       (wgt_in),
        .result       (result),
        .result_valid (result_valid),
        .result_addr  (result_addr),
        .layer_done   (layer_done)
    );

    always #5 clk = ~clk;

    int img [0:1023];
    int wgt [0:1023];
    int cur_addr = 0;
    int cyc = 0;

    // Image and weight RAMs: read data appears one cycle after the address/count
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        pix_in <= en ? 8'(img[cur_addr]) : 8'($urandom);
        wgt_in <= en ? 8'(wgt[count]) : 8'($urandom);
    end

    typedef struct {
        int val;
        int addr;
        int done;
    } exp_t;

    typedef struct {
        int hs, ws, hl, wl;
        int pmode;   // 0: 1,2,3..  1: all 255  2: random
        int wmode;   // -128..127 constant, 1000 random full range, 1001 random small
        int gaps;
        int exp0;    // expected first result, NONE to rely on the model only
    } vec_t;

    localparam int NONE = 99999;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   nvalid, first_cyc, first_val, last_en_cyc;

    function automatic int sat_model(input int s);
        int r;
        r = s;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`ifdef CONV_L1_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (result_valid === 1'b1) begin
            if (nvalid == 0) begin
                first_cyc = cyc;
                first_val = int'($signed(result));
            end
            nvalid++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_valid: got result_valid=1 addr=%0d expected no result", result_addr);
            end else begin
                e = expq.pop_front();
                check("result", int'($signed(result)), e.val);
                check("result_addr", int'(result_addr), e.addr);
                check("layer_done", int'(layer_done), e.done);
            end
        end else if (layer_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_without_valid: got layer_done=1 expected 0");
        end
    endtask

    task automatic step(input bit e, input int c, input int a, input bit r);
        @(negedge clk);
        sample();
        en       = e;
        count    = 10'(c);
        cur_addr = a;
        rst      = r;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("reset_result", int'(result), 0);
        check("reset_valid", int'(result_valid), 0);
        check("reset_addr", int'(result_addr), 0);
        check("reset_done", int'(layer_done), 0);
        nvalid = 0;
    endtask

    // Loads the RAM contents and queues the expected result of every window
    task automatic setup(input int hs, input int ws, input int hl, input int wl,
                         input int pmode, input int wmode);
        int oh, ow, sum;
        ht_sm = 9'(hs); wt_sm = 9'(ws); ht_lg = 9'(hl); wt_lg = 9'(wl);
        for (int i = 0; i < hl * wl; i++) begin
            if (pmode == 0) img[i] = i + 1;
            else if (pmode == 1) img[i] = 255;
            else img[i] = int'($urandom_range(0, 255));
        end
        for (int i = 0; i < hs * ws; i++) begin
            if (wmode == 1000) wgt[i] = int'($urandom_range(0, 255)) - 128;
            else if (wmode == 1001) wgt[i] = int'($urandom_range(0, 15)) - 8;
            else wgt[i] = wmode;
        end
        oh = hl - hs + 1;
        ow = wl - ws + 1;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                sum = 0;
                for (int ky = 0; ky < hs; ky++)
                    for (int kx = 0; kx < ws; kx++)
                        sum += img[(oy + ky) * wl + ox + kx] * wgt[ky * ws + kx];
                expq.push_back('{sat_model(sum), oy * ow + ox,
                                 (oy == oh - 1 && ox == ow - 1) ? 1 : 0});
            end
        end
    endtask

    task automatic run_window(input int oy, input int ox, input int ncnt, input int gaps,
                              input bit first_win);
        int hs, ws, wl;
        hs = int'(ht_sm); ws = int'(wt_sm); wl = int'(wt_lg);
        for (int c = 0; c < ncnt; c++) begin
            if (gaps != 0 && ((c == 0 && !first_win) || $urandom_range(0, 3) == 0))
                repeat ($urandom_range(1, 3)) step(0, int'($urandom_range(0, 1023)), 0, 0);
            step(1, c, (oy + c / ws) * wl + ox + c % ws, 0);
            if (first_win && c == hs * ws - 1) last_en_cyc = cyc;
        end
    endtask

    task automatic run_layer(input int gaps);
        int oh, ow;
        oh = int'(ht_lg) - int'(ht_sm) + 1;
        ow = int'(wt_lg) - int'(wt_sm) + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                run_window(oy, ox, int'(ht_sm) * int'(wt_sm), gaps, (oy == 0 && ox == 0));
    endtask

    task automatic drain();
        repeat (12) step(0, int'($urandom_range(0, 1023)), 0, 0);
        check("queue_drained", expq.size(), 0);
    endtask

    vec_t vecs [7];
    exp_t e0;

    initial begin
        vecs[0] = '{2, 2, 3, 3, 0, 1, 0, 12};
        vecs[1] = '{3, 3, 3, 3, 1, 127, 0, 32767};
`ifdef CONV_L1_RELU_EN
        vecs[2] = '{3, 3, 3, 3, 1, -128, 0, 0};
`else
        vecs[2] = '{3, 3, 3, 3, 1, -128, 0, -32768};
`endif
        vecs[3] = '{1, 1, 4, 4, 0, 2, 0, 2};
        vecs[4] = '{3, 3, 6, 5, 2, 1001, 1, NONE};
        vecs[5] = '{2, 3, 5, 7, 2, 1000, 1, NONE};
        vecs[6] = '{4, 4, 8, 9, 2, 1001, 0, NONE};

        for (int v = 0; v < 7; v++) begin
            expq.delete();
            do_reset();
            setup(vecs[v].hs, vecs[v].ws, vecs[v].hl, vecs[v].wl, vecs[v].pmode, vecs[v].wmode);
            run_layer(vecs[v].gaps);
            drain();
            check("valid_count", nvalid,
                  (vecs[v].hl - vecs[v].hs + 1) * (vecs[v].wl - vecs[v].ws + 1));
            check("first_latency", first_cyc - last_en_cyc, 3);
            if (vecs[v].exp0 != NONE) check("first_result", first_val, vecs[v].exp0);
        end

        // Reset during window 1: only window 0 may complete, then a clean restart
        expq.delete();
        do_reset();
        setup(2, 2, 3, 3, 0, 1);
        e0 = expq[0];
        expq.delete();
        expq.push_back(e0);
        run_window(0, 0, 4, 0, 1'b1);
        step(1, 0, 1, 0);
        step(1, 1, 2, 0);
        step(1, 2, 4, 1);
        step(0, 0, 0, 1);
        repeat (8) step(0, 0, 0, 0);
        check("reset_inflight_results", nvalid, 1);
        check("reset_queue", expq.size(), 0);
        nvalid = 0;
        setup(2, 2, 3, 3, 0, 1);
        run_layer(0);
        drain();
        check("restart_count", nvalid, 4);
        check("restart_first", first_val, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_mac_l1.md
# conv_mac_l1

Layer-1 convolution multiply-accumulate stage, directly downstream of the layer-1 address generator. It consumes the image pixel read from the large-array RAM at the generated address and the kernel weight read at the same window `count`. It accumulates one window of `ht_sm*wt_sm` products and emits one saturated signed result per window, together with its linear output-feature-map address. It also raises a one-cycle `layer_done` when the last window of the layer completes.

## Interface
Parameters:
- `PIX_W`, 8: unsigned pixel width.
- `WGT_W`, 8: signed weight width.
- `ACC_W`, 27: signed accumulator width; holds 1024 × 17-bit products.
- `OUT_W`, 16: signed result width after saturation.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  same enable that steps the address generator; `count`, address and RAM reads are valid this cycle.
- `count`  in  10  kernel element index within the window, 0..`ht_sm*wt_sm-1`.
- `ht_sm`, `wt_sm`  in  9 each  kernel height and width.
- `ht_lg`, `wt_lg`  in  9 each  image height and width.
- `pix_in`  in  PIX_W  RAM read data, one cycle after the address.
- `wgt_in`  in  WGT_W  weight RAM read data, one cycle after `count`.
- `result`  out  OUT_W  window sum, saturated.
- `result_valid`  out  1  one-cycle strobe qualifying `result` and `result_addr`.
- `result_addr`  out  18  output map index, `oy*(wt_lg-wt_sm+1)+ox`.
- `layer_done`  out  1  one-cycle pulse coincident with the final `result_valid`.

## Operation
- **Reset values.** All outputs are 0. The accumulator, the output index and all pipeline valid bits are 0, and the FSM is in IDLE.
- **S0 (cycle of `en`).** Register `v0=en` and `last0=(count==ht_sm*wt_sm-1)`. The `ht_sm*wt_sm` product is 18 bits; compare it on 10 bits.
- **S1.** If `v0`, register `prod = {1'b0,pix_in} * wgt_in` as a 17-bit signed value. Pass `v1` and `last1` along with it.
- **S2, accumulate.**
  - If `v1` and the FSM is IDLE, or `first1` is set: `acc = sext(prod)`. Otherwise, if `v1`: `acc = acc + sext(prod)`.
  - If `v1 && last1`: drive `result = sat(acc_next)`, `result_valid = 1`, and return the FSM to IDLE.
- **FSM states.**
  - IDLE → ACC on `v1 && !last1`.
  - IDLE stays IDLE on `v1 && last1` (1×1 kernel).
  - ACC → IDLE on `v1 && last1`.
  - Cycles with `v1 = 0` hold both state and accumulator.
- **Saturation.**
  - `acc_next > 2^(OUT_W-1)-1` → result is `0x7FFF`.
  - `acc_next < -2^(OUT_W-1)` → result is `0x8000`.
  - Otherwise the result is a truncation of `acc_next`.
  - The accumulator itself never wraps, since N ≤ 1024.
- **Output index.**
  - `result_addr` shows the index of the current result.
  - The internal index register increments after each `result_valid`.
  - When the index reaches `(ht_lg-ht_sm+1)*(wt_lg-wt_sm+1)-1`, that result also asserts `layer_done` and the index wraps to 0.
- **Configuration inputs.** `en = 0` inserts bubbles only; partial window sums are held. Changing `ht_*`/`wt_*` mid-layer is unsupported; the block must be reset first.

## Timing
- Latency is 3 cycles: `en` with `count = N-1` sampled at cycle t → `result_valid` high at t+3.
- Throughput is one product per cycle and one result per N enabled cycles, back-to-back.
- On consecutive windows, the final product of window k and the first product of window k+1 occupy adjacent S2 cycles. S2 must restart the sum with no lost or doubled term.
- `rst` asserted mid-window:
  - Partial sum, index and pipeline valid bits are discarded on the next edge.
  - No `result_valid` for any in-flight data.
- `layer_done` is never asserted without `result_valid` in the same cycle.

## Configuration
- `CONV_L1_RELU_EN` defined:
  - After saturation, any negative result becomes 0 (ReLU).
  - `result` is still OUT_W wide, and its MSB is always 0.
- Not defined: the saturated signed result passes unchanged.
- Latency is identical in both builds.

## Structure
- Shared package `cnn_l1_pkg`:
  - `PIX_W`, `WGT_W`, `ACC_W`, `OUT_W`.
  - FSM state enum `{IDLE, ACC}`.
  - Saturation limit constants.
- One sub-module, `sat_relu_l1`: combinational saturation plus the optional ReLU. It takes `ACC_W` in and gives `OUT_W` out, and the macro is evaluated there.

## Test plan
- **2×2 kernel over a 3×3 image.** Pixels 1..9, weights {1,1,1,1}, `en` held high.
  - Results 12, 16, 24, 28 at `result_addr` 0..3.
  - First result 3 cycles after `count = 3`.
  - `layer_done` with `addr = 3`.
- **Positive saturation.** 3×3 kernel, all pixels 255, all weights 127 → sum 291465; `result = 0x7FFF`.
- **Negative saturation.** Weights -128 → `result = 0x8000`.
  - With `CONV_L1_RELU_EN` defined, the same case gives `result = 0`.
- **Bubbles.** Random `en` gaps, including a gap at the `count = N-1` → `count = 0` boundary → results identical to the gap-free run; `result_valid` count equals the number of windows.
- **1×1 kernel.** Pixel p, weight 2, `en` high → `result = 2p` every cycle after the 3-cycle fill; `result_addr` increments every cycle.
- **Reset mid-operation.** `rst` asserted at `count = 2` of window 1, then released and the layer restarted → no stale `result_valid`; the first result has `result_addr = 0` and the correct sum.
